// File: rtl/channel_joiner_if.sv
// Handshake bundle between the TDM receive stream and the per-channel outputs.
// master drives the stream side; slave is the joiner itself.
interface channel_joiner_if;
   logic        holder;
   logic [7:0]  data_in;
   logic [3:0]  en;
   logic [7:0]  ch0;
   logic [7:0]  ch1;
   logic [7:0]  ch2;
   logic [7:0]  ch3;
   logic [3:0]  ch_valid;
   logic [1:0]  seg;
   logic [7:0]  sample_idx;
   logic        frame_done;
   logic [15:0] frame_count;
   logic        err_nonzero;

   modport master (
      output holder, data_in, en,
      input  ch0, ch1, ch2, ch3, ch_valid, seg,
      input  sample_idx, frame_done, frame_count, err_nonzero
   );

   modport slave (
      input  holder, data_in, en,
      output ch0, ch1, ch2, ch3, ch_valid, seg,
      output sample_idx, frame_done, frame_count, err_nonzero
   );
endinterface

// File: rtl/channel_joiner.sv
// Four-channel TDM de-multiplexer: rebuilds the transmitter schedule from holder
// and steers each sample into its channel register, counting frames.
module channel_joiner #(
   parameter int LEN0 = 143,
   parameter int LEN1 = 110,
   parameter int LEN2 = 77,
   parameter int LEN3 = 44
) (
   input logic             clk,
   input logic             rst_n,
   channel_joiner_if.slave bus
);
   localparam logic [7:0] L0 = 8'(LEN0 - 1);
   localparam logic [7:0] L1 = 8'(LEN1 - 1);
   localparam logic [7:0] L2 = 8'(LEN2 - 1);
   localparam logic [7:0] L3 = 8'(LEN3 - 1);

   logic [1:0]       r_cur_seg;
   logic [7:0]       r_cur_cnt;
   logic [1:0]       r_tag_seg;
   logic [7:0]       r_tag_cnt;
   logic             r_primed;
   logic [3:0][7:0]  r_ch;
   logic [3:0]       r_ch_valid;
   logic [1:0]       r_seg;
   logic [7:0]       r_idx;
   logic             r_frame_done;
   logic [15:0]      r_frame_count;
   logic             r_err;

   logic [7:0]       w_last;
   logic             w_acc;
   logic             w_en_s;
   logic             w_fdone;

   always_comb begin
      w_last = L0;
      unique case (r_cur_seg)
         2'd0: w_last = L0;
         2'd1: w_last = L1;
         2'd2: w_last = L2;
         2'd3: w_last = L3;
      endcase
   end

   // the transmitter output lags its schedule by one edge, so accept the tag
   // captured on the previous edge
   assign w_acc   = bus.holder & r_primed;
   assign w_en_s  = bus.en[r_tag_seg];
   assign w_fdone = w_acc && (r_tag_seg == 2'd3) && (r_tag_cnt == L3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_seg <= '0;
         r_cur_cnt <= '0;
         r_tag_seg <= '0;
         r_tag_cnt <= '0;
         r_primed  <= 1'b0;
      end else if (!bus.holder) begin
         r_cur_seg <= '0;
         r_cur_cnt <= '0;
         r_primed  <= 1'b0;
      end else begin
         r_tag_seg <= r_cur_seg;
         r_tag_cnt <= r_cur_cnt;
         r_primed  <= 1'b1;
         if (r_cur_cnt == w_last) begin
            r_cur_cnt <= '0;
            r_cur_seg <= r_cur_seg + 2'd1;
         end else begin
            r_cur_cnt <= r_cur_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ch          <= '0;
         r_ch_valid    <= '0;
         r_seg         <= '0;
         r_idx         <= '0;
         r_frame_done  <= 1'b0;
         r_frame_count <= '0;
         r_err         <= 1'b0;
      end else begin
         r_ch_valid   <= '0;
         r_frame_done <= w_fdone;
         if (w_acc) begin
            r_seg <= r_tag_seg;
            r_idx <= r_tag_cnt;
            if (w_en_s) begin
               r_ch[r_tag_seg] <= bus.data_in;
               r_ch_valid      <= 4'b0001 << r_tag_seg;
            end else if (bus.data_in != 8'd0) begin
               r_err <= 1'b1;
            end
            if (w_fdone) r_frame_count <= r_frame_count + 16'd1;
         end
      end
   end

   assign bus.ch0         = r_ch[0];
   assign bus.ch1         = r_ch[1];
   assign bus.ch2         = r_ch[2];
   assign bus.ch3         = r_ch[3];
   assign bus.ch_valid    = r_ch_valid;
   assign bus.seg         = r_seg;
   assign bus.sample_idx  = r_idx;
   assign bus.frame_done  = r_frame_done;
   assign bus.frame_count = r_frame_count;
   assign bus.err_nonzero = r_err;
endmodule
